unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/unified_mem_arbiter_starve_counter.sv | 35 +++
 rtl/unified_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
// FSM states, grant encoding, bus widths.
package mem_arb_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic {
    S_CPU,
    S_DMA
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_DM,
    GNT_DMA
  } gnt_e;

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating count of consecutive denied cycles.
// starved flags that the limit has been reached.
module starve_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned W =
    (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Count denied cycles; any grant or idle cycle clears.
  always_comb begin
    cnt_d = '0;
    if (req && !gnt) begin
      if (cnt_q == W'(LIMIT)) cnt_d = cnt_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign starved = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port RAM arbiter: fetch, CPU data, DMA.
// DMA bursts lock the port; starvation overrides.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic [3:0]    dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_stall,
  input  logic          dma_req,
  input  logic [3:0]    dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_last,
  output logic          dma_gnt,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic [3:0]    ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  state_e        state_d;
  state_e        state_q;
  logic [BW-1:0] burst_d;
  logic [BW-1:0] burst_q;
  gnt_e          gnt;
  logic          if_starved;
  logic          dma_starved;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_if_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (if_req),
    .gnt     (gnt == GNT_IF),
    .starved (if_starved)
  );

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_dma_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (dma_req),
    .gnt     (gnt == GNT_DMA),
    .starved (dma_starved)
  );

  // Pick one winner; reset masks all grants so no
  // write can reach the RAM while rst_n is low.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst_n) gnt = GNT_NONE;
    else if (dma_req &&
             (state_q == S_DMA || dma_starved))
      gnt = GNT_DMA;
    else if (if_req && if_starved) gnt = GNT_IF;
    else if (dm_req) gnt = GNT_DM;
    else if (if_req) gnt = GNT_IF;
    else if (dma_req) gnt = GNT_DMA;
  end

  // Steer the winner onto the RAM port.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = '0;
    unique case (gnt)
      GNT_IF: ram_addr = if_addr;
      GNT_DM: begin
        ram_addr  = dm_addr;
        ram_wdata = dm_wdata;
        ram_we    = dm_we;
      end
      GNT_DMA: begin
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
        ram_we    = dma_we;
      end
      default: ;
    endcase
  end

  assign if_stall = if_req && (gnt != GNT_IF);
  assign dm_stall = dm_req && (gnt != GNT_DM);
  assign dma_gnt  = (gnt == GNT_DMA);
  assign rdata    = ram_rdata;

  // Burst lock: enter on a non-final DMA beat, leave on
  // last beat, DMA idle, or the beat cap.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (state_q == S_CPU) begin
      if (gnt == GNT_DMA && !dma_last &&
          MAX_BURST > 1) begin
        state_d = S_DMA;
        burst_d = BW'(1);
      end
    end else if (gnt == GNT_DMA) begin
      burst_d = burst_q + 1'b1;
      if (dma_last || burst_d == BW'(MAX_BURST)) begin
        state_d = S_CPU;
        burst_d = '0;
      end
    end else begin
      state_d = S_CPU;
      burst_d = '0;
    end
  end

  // FSM and burst registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CPU;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Random + directed bench for unified_mem_arbiter.
// Reference model tracks waits and burst lock.
module tb_unified_mem_arbiter;

  localparam int STARVE = 4;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_stall;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_stall;
  logic        dma_req;
  logic [3:0]  dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_last;
  logic        dma_gnt;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] rdata;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  int m_ifw;
  int m_dmaw;
  int m_beats;
  bit m_lock;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .STARVE_LIMIT(STARVE),
    .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata),
    .rdata(rdata)
  );

  assign ram_rdata = mem[ram_addr[11:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b])
        mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ifw = 0;
    m_dmaw = 0;
    m_beats = 0;
    m_lock = 0;
  endtask

  // 0 none, 1 fetch, 2 data, 3 dma
  function automatic int pick();
    if (dma_req && (m_lock || m_dmaw == STARVE))
      return 3;
    if (if_req && m_ifw == STARVE) return 1;
    if (dm_req) return 2;
    if (if_req) return 1;
    if (dma_req) return 3;
    return 0;
  endfunction

  task automatic model_update(input int g);
    if (if_req && g != 1)
      m_ifw = (m_ifw < STARVE) ? m_ifw + 1 : STARVE;
    else m_ifw = 0;
    if (dma_req && g != 3)
      m_dmaw = (m_dmaw < STARVE) ? m_dmaw + 1 : STARVE;
    else m_dmaw = 0;
    if (g == 3) begin
      if (!m_lock) begin
        if (!dma_last) begin
          m_lock = 1;
          m_beats = 1;
        end
      end else begin
        m_beats++;
        if (dma_last || m_beats == MAXB) m_lock = 0;
      end
    end else if (m_lock) begin
      m_lock = 0;
    end
  endtask

  task automatic step();
    int g;
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  ewe;
    #1;
    g = pick();
    ea = '0;
    ew = '0;
    ewe = '0;
    case (g)
      1: ea = if_addr;
      2: begin ea = dm_addr; ew = dm_wdata; ewe = dm_we; end
      3: begin ea = dma_addr; ew = dma_wdata; ewe = dma_we; end
      default: ;
    endcase
    chk("if_stall", if_stall, if_req && g != 1);
    chk("dm_stall", dm_stall, dm_req && g != 2);
    chk("dma_gnt", dma_gnt, g == 3);
    chk("ram_addr", ram_addr, ea);
    chk("ram_wdata", ram_wdata, ew);
    chk("ram_we", ram_we, ewe);
    chk("rdata", rdata, mem[ea[11:2]]);
    @(posedge clk);
    model_update(g);
    @(negedge clk);
  endtask

  task automatic idle();
    if_req = 0;
    dm_req = 0;
    dma_req = 0;
    dma_last = 0;
    dm_we = 0;
    dma_we = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    model_reset();
    rst_n = 0;
    if_req = 0;
    if_addr = 32'h10;
    dm_req = 1;
    dm_we = 4'hF;
    dm_addr = 32'h20;
    dm_wdata = 32'h55;
    dma_req = 1;
    dma_we = 4'hF;
    dma_addr = 32'h30;
    dma_wdata = 32'h66;
    dma_last = 0;
    #3;
    chk("rst_ram_we", ram_we, 4'h0);
    chk("rst_dma_gnt", dma_gnt, 1'b0);
    @(negedge clk);
    rst_n = 1;
    idle();

    // fetch starvation override
    if_req = 1;
    dm_req = 1;
    dm_we = 0;
    if_addr = 32'h200;
    dm_addr = 32'h204;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("starve_if_stall", if_stall, k != 4);
      chk("starve_dm_stall", dm_stall, k == 4);
      step();
    end
    idle();

    // three-beat DMA write
    for (int k = 0; k < 3; k++) begin
      dma_req = 1;
      dma_we = 4'hF;
      dma_addr = 32'h100 + 32'(4 * k);
      dma_wdata = 32'hA + 32'(k);
      dma_last = (k == 2);
      #1;
      chk("burst3_gnt", dma_gnt, 1'b1);
      step();
    end
    dma_req = 1;
    dma_last = 0;
    dma_we = 0;
    dm_req = 1;
    dm_we = 0;
    dm_addr = 32'h100;
    #1;
    chk("burst3_release", dma_gnt, 1'b0);
    step();
    chk("mem_100", mem[32'h100 >> 2], 32'hA);
    chk("mem_104", mem[32'h104 >> 2], 32'hB);
    chk("mem_108", mem[32'h108 >> 2], 32'hC);
    idle();

    // forced release after MAX_BURST beats
    for (int k = 0; k < 20; k++) begin
      dma_req = 1;
      dma_we = 4'h0;
      dma_addr = 32'h300 + 32'(4 * k);
      dma_last = 0;
      dm_req = (k >= 1 && k <= 16);
      dm_we = 0;
      dm_addr = 32'h108;
      #1;
      if (k < 16)
        chk("cap_dma_gnt", dma_gnt, 1'b1);
      if (k == 16) begin
        chk("cap_release_dma", dma_gnt, 1'b0);
        chk("cap_release_dm", dm_stall, 1'b0);
      end
      step();
    end
    idle();

    // data store beats pending DMA
    dm_req = 1;
    dm_we = 4'hF;
    dm_addr = 32'h40;
    dm_wdata = 32'hF;
    dma_req = 1;
    dma_we = 4'hF;
    dma_addr = 32'h44;
    #1;
    chk("dm_win_dma_gnt", dma_gnt, 1'b0);
    chk("dm_win_stall", dm_stall, 1'b0);
    step();
    dma_req = 0;
    dm_we = 0;
    #1;
    chk("dm_readback", rdata, 32'h0000000F);
    step();
    idle();

    // reset in the middle of a burst
    for (int k = 0; k < 4; k++) begin
      dma_req = 1;
      dma_we = 4'hF;
      dma_addr = 32'h380 + 32'(4 * k);
      dma_last = 0;
      step();
    end
    #2;
    rst_n = 0;
    #1;
    chk("midrst_ram_we", ram_we, 4'h0);
    chk("midrst_dma_gnt", dma_gnt, 1'b0);
    @(negedge clk);
    model_reset();
    rst_n = 1;
    dma_req = 0;
    if_req = 1;
    if_addr = 32'h3C0;
    #1;
    chk("postrst_if_stall", if_stall, 1'b0);
    chk("postrst_addr", ram_addr, 32'h3C0);
    step();
    if_req = 0;
    dm_req = 1;
    dma_req = 1;
    step();
    idle();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      if_req = ($urandom_range(0, 1) == 1);
      dm_req = ($urandom_range(0, 1) == 1);
      dma_req = ($urandom_range(0, 2) != 0);
      if_addr = $urandom & 32'hFFC;
      dm_addr = $urandom & 32'hFFC;
      dma_addr = $urandom & 32'hFFC;
      dm_we = 4'($urandom);
      dma_we = 4'($urandom);
      dm_wdata = $urandom;
      dma_wdata = $urandom;
      dma_last = ($urandom_range(0, 5) == 0);
      step();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
